// File: rtl/caxi4interconnect_resp_router_pkg.sv
// Shared interconnect definitions: AXI RRESP encodings, buffer occupancy
// states and the rule for how wide a routed RID is.
package caxi4interconnect_resp_router_pkg;

    localparam int RESP_WIDTH = 2;

    typedef enum logic [1:0] {
        RRESP_OKAY   = 2'd0,
        RRESP_EXOKAY = 2'd1,
        RRESP_SLVERR = 2'd2,
        RRESP_DECERR = 2'd3
    } rresp_e;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    // A routed RID carries the return port above the original transaction ID.
    function automatic int ridWidth(input int numSlavesWidth, input int idWidth);
        return numSlavesWidth + idWidth;
    endfunction

    // The port field starts directly above the original ID bits.
    function automatic int portFieldLsb(input int idWidth);
        return idWidth;
    endfunction

endpackage

// File: rtl/caxi4interconnect_resp_skid_buf.sv
// Two-entry FIFO skid buffer; the input ready is registered so the
// consumer's pop never reaches the producer combinationally.
module caxi4interconnect_resp_skid_buf
    import caxi4interconnect_resp_router_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inValid_i,
    output logic             inReady_o,
    input  logic [WIDTH-1:0] inData_i,
    input  logic             pop_i,
    output logic             outValid_o,
    output logic [WIDTH-1:0] outData_o
);

    occ_e             occ_q, occ_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             ready_q;
    logic             push;
    logic             pop;

    assign push = inValid_i && ready_q;
    assign pop  = pop_i && (occ_q != OCC_EMPTY);

    // Emptied slots are zeroed so stale beats never linger in the registers.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case (occ_q)
            OCC_EMPTY: begin
                if (push) begin
                    head_d = inData_i;
                    occ_d  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (push && pop) begin
                    head_d = inData_i;
                end else if (push) begin
                    tail_d = inData_i;
                    occ_d  = OCC_TWO;
                end else if (pop) begin
                    head_d = '0;
                    occ_d  = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (pop) begin
                    head_d = tail_q;
                    tail_d = '0;
                    occ_d  = OCC_ONE;
                end
            end
            default: begin
                head_d = '0;
                tail_d = '0;
                occ_d  = OCC_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q   <= OCC_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ready_q <= (occ_d != OCC_TWO);
        end
    end

    assign inReady_o  = ready_q;
    assign outValid_o = (occ_q != OCC_EMPTY);
    assign outData_o  = head_q;

endmodule

// File: rtl/caxi4interconnect_resp_router.sv
// Routes buffered read-response beats back to the requesting slave port
// named in the upper RID bits; beats to unusable ports are dropped with DECERR.
module caxi4interconnect_resp_router
    import caxi4interconnect_resp_router_pkg::*;
#(
    parameter int NUM_SLAVES       = 8,
    parameter int NUM_SLAVES_WIDTH = 3,
    parameter int ID_WIDTH         = 1,
    parameter int DATA_WIDTH       = 32
) (
    input  logic                               ACLK,
    input  logic                               sysReset,
    input  logic                               MASTER_RVALID,
    output logic                               MASTER_RREADY,
    input  logic [NUM_SLAVES_WIDTH+ID_WIDTH-1:0] MASTER_RID,
    input  logic [DATA_WIDTH-1:0]              MASTER_RDATA,
    input  logic [1:0]                         MASTER_RRESP,
    input  logic                               MASTER_RLAST,
    input  logic [NUM_SLAVES-1:0]              READ_CONNECTIVITY,
    output logic [NUM_SLAVES-1:0]              SLAVE_RVALID,
    input  logic [NUM_SLAVES-1:0]              SLAVE_RREADY,
    output logic [ID_WIDTH-1:0]                SLAVE_RID,
    output logic [DATA_WIDTH-1:0]              SLAVE_RDATA,
    output logic [1:0]                         SLAVE_RRESP,
    output logic                               SLAVE_RLAST,
    output logic                               DECERR_PULSE,
    output logic                               DECERR_STICKY
);

    localparam int RID_W    = ridWidth(NUM_SLAVES_WIDTH, ID_WIDTH);
    localparam int PORT_LSB = portFieldLsb(ID_WIDTH);
    localparam int PAY_W    = RID_W + DATA_WIDTH + RESP_WIDTH + 1;

    logic [PAY_W-1:0]            inPayload;
    logic [PAY_W-1:0]            headPayload;
    logic                        headValid;
    logic                        popHead;
    logic [RID_W-1:0]            headRid;
    logic [DATA_WIDTH-1:0]       headData;
    logic [1:0]                  headResp;
    logic                        headLast;
    logic [NUM_SLAVES_WIDTH-1:0] headPort;
    logic [NUM_SLAVES-1:0]       portHit;
    logic                        routable;
    logic                        dropHead;
    logic                        decerrSticky_q;
    logic                        decerrSticky_d;

    assign inPayload = {MASTER_RID, MASTER_RDATA, MASTER_RRESP, MASTER_RLAST};

    caxi4interconnect_resp_skid_buf #(
        .WIDTH (PAY_W)
    ) u_skidBuf (
        .clk_i      (ACLK),
        .rst_ni     (sysReset),
        .inValid_i  (MASTER_RVALID),
        .inReady_o  (MASTER_RREADY),
        .inData_i   (inPayload),
        .pop_i      (popHead),
        .outValid_o (headValid),
        .outData_o  (headPayload)
    );

    assign {headRid, headData, headResp, headLast} = headPayload;
    assign headPort = headRid[PORT_LSB +: NUM_SLAVES_WIDTH];

    // Ports beyond NUM_SLAVES never match, so out-of-range heads are unroutable.
    always_comb begin
        portHit = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            portHit[i] = (32'(headPort) == 32'(i)) && READ_CONNECTIVITY[i];
        end
    end

    assign routable     = |portHit;
    assign dropHead     = headValid && !routable;
    assign SLAVE_RVALID = headValid ? portHit : '0;
    assign popHead      = dropHead || (|(SLAVE_RVALID & SLAVE_RREADY));

    assign SLAVE_RID    = headValid ? headRid[ID_WIDTH-1:0] : '0;
    assign SLAVE_RDATA  = headValid ? headData : '0;
    assign SLAVE_RRESP  = headValid ? headResp : '0;
    assign SLAVE_RLAST  = headValid && headLast;
    assign DECERR_PULSE = dropHead;

    assign decerrSticky_d = decerrSticky_q || dropHead;

    always_ff @(posedge ACLK or negedge sysReset) begin
        if (!sysReset) begin
            decerrSticky_q <= 1'b0;
        end else begin
            decerrSticky_q <= decerrSticky_d;
        end
    end

    assign DECERR_STICKY = decerrSticky_q;

endmodule

// File: tb/tb_caxi4interconnect_resp_router.sv
// Scoreboard bench for the response router: a default 8-port instance
// with a queue-driven monitor, plus a 6-port instance for out-of-range ports.
module tb_caxi4interconnect_resp_router;
    import caxi4interconnect_resp_router_pkg::*;

    typedef struct {
        logic        drop;
        logic [2:0]  port;
        logic        id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } exp_t;

    logic        ACLK;
    logic        sysReset;

    logic        mRvalid, mRready, mRlast;
    logic [3:0]  mRid;
    logic [31:0] mRdata;
    logic [1:0]  mRresp;
    logic [7:0]  conn, sRvalid, sRready;
    logic        sRid, sRlast, dPulse, dSticky;
    logic [31:0] sRdata;
    logic [1:0]  sRresp;

    logic        m6Rvalid, m6Rready, m6Rlast;
    logic [3:0]  m6Rid;
    logic [31:0] m6Rdata;
    logic [1:0]  m6Rresp;
    logic [5:0]  conn6, s6Rvalid, s6Rready;
    logic        s6Rid, s6Rlast, d6Pulse, d6Sticky;
    logic [31:0] s6Rdata;
    logic [1:0]  s6Rresp;

    exp_t sbQ[$];
    exp_t e;
    int   testsRun = 0;
    int   failures = 0;
    int   pulseCount = 0;
    int   acceptedCount = 0;
    logic stimDone;

    caxi4interconnect_resp_router dut (
        .ACLK              (ACLK),
        .sysReset          (sysReset),
        .MASTER_RVALID     (mRvalid),
        .MASTER_RREADY     (mRready),
        .MASTER_RID        (mRid),
        .MASTER_RDATA      (mRdata),
        .MASTER_RRESP      (mRresp),
        .MASTER_RLAST      (mRlast),
        .READ_CONNECTIVITY (conn),
        .SLAVE_RVALID      (sRvalid),
        .SLAVE_RREADY      (sRready),
        .SLAVE_RID         (sRid),
        .SLAVE_RDATA       (sRdata),
        .SLAVE_RRESP       (sRresp),
        .SLAVE_RLAST       (sRlast),
        .DECERR_PULSE      (dPulse),
        .DECERR_STICKY     (dSticky)
    );

    caxi4interconnect_resp_router #(
        .NUM_SLAVES       (6),
        .NUM_SLAVES_WIDTH (3),
        .ID_WIDTH         (1),
        .DATA_WIDTH       (32)
    ) dut6 (
        .ACLK              (ACLK),
        .sysReset          (sysReset),
        .MASTER_RVALID     (m6Rvalid),
        .MASTER_RREADY     (m6Rready),
        .MASTER_RID        (m6Rid),
        .MASTER_RDATA      (m6Rdata),
        .MASTER_RRESP      (m6Rresp),
        .MASTER_RLAST      (m6Rlast),
        .READ_CONNECTIVITY (conn6),
        .SLAVE_RVALID      (s6Rvalid),
        .SLAVE_RREADY      (s6Rready),
        .SLAVE_RID         (s6Rid),
        .SLAVE_RDATA       (s6Rdata),
        .SLAVE_RRESP       (s6Rresp),
        .SLAVE_RLAST       (s6Rlast),
        .DECERR_PULSE      (d6Pulse),
        .DECERR_STICKY     (d6Sticky)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Offers one beat and waits for the master handshake; the expected
    // outcome is queued only once the beat is actually accepted.
    task automatic applyStimulus(input logic [2:0] port, input logic id, input logic [31:0] data,
                                 input logic [1:0] resp, input logic last, input logic drop);
        logic rdy;
        int   budget;
        budget  = 0;
        mRvalid = 1'b1;
        mRid    = {port, id};
        mRdata  = data;
        mRresp  = resp;
        mRlast  = last;
        do begin
            @(negedge ACLK);
            rdy = mRready;
            @(posedge ACLK);
            #1;
            budget++;
        end while (!rdy && budget < 100);
        if (!rdy) begin
            testsRun++;
            failures++;
            $display("[TB] FAIL accept_timeout: port %0d data 0x%0h never accepted", port, data);
        end else begin
            sbQ.push_back('{drop, port, id, data, resp, last});
            acceptedCount++;
        end
    endtask

    task automatic idleMaster();
        mRvalid = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int budget;
        budget = 0;
        while (sbQ.size() != 0 && budget < 200) begin
            @(posedge ACLK);
            #1;
            budget++;
        end
        checkOutput(name, 64'(sbQ.size()), 64'(0));
    endtask

    // Monitor: every delivered or dropped beat must match the queue head.
    always @(negedge ACLK) begin
        if (sysReset) begin
            if (dPulse) begin
                pulseCount++;
                if (sbQ.size() == 0) begin
                    testsRun++;
                    failures++;
                    $display("[TB] FAIL sb_drop_underflow: DECERR pulse with nothing expected");
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("sb_drop_expected", 64'(1'b1), 64'(e.drop));
                    checkOutput("sb_drop_rvalid", 64'(sRvalid), 64'(0));
                end
            end else if ((sRvalid & sRready) != 8'h00) begin
                if (sbQ.size() == 0) begin
                    testsRun++;
                    failures++;
                    $display("[TB] FAIL sb_route_underflow: rvalid 0x%0h with nothing expected", sRvalid);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("sb_route_drop", 64'(1'b0), 64'(e.drop));
                    checkOutput("sb_rvalid", 64'(sRvalid), 64'(8'd1 << e.port));
                    checkOutput("sb_rid", 64'(sRid), 64'(e.id));
                    checkOutput("sb_rdata", 64'(sRdata), 64'(e.data));
                    checkOutput("sb_rresp", 64'(sRresp), 64'(e.resp));
                    checkOutput("sb_rlast", 64'(sRlast), 64'(e.last));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int base;
        stimDone = 1'b0;
        mRvalid  = 1'b0; mRid = '0; mRdata = '0; mRresp = '0; mRlast = 1'b0;
        conn     = 8'hFF; sRready = 8'hFF;
        m6Rvalid = 1'b0; m6Rid = '0; m6Rdata = '0; m6Rresp = '0; m6Rlast = 1'b0;
        conn6    = 6'h3F; s6Rready = 6'h3F;
        sysReset = 1'b1;
        #1 sysReset = 1'b0;

        // Reset state
        repeat (2) @(negedge ACLK);
        checkOutput("rst_rready", 64'(mRready), 64'(0));
        checkOutput("rst_rvalid", 64'(sRvalid), 64'(0));
        checkOutput("rst_rdata", 64'(sRdata), 64'(0));
        checkOutput("rst_sticky", 64'(dSticky), 64'(0));
        checkOutput("rst_pulse", 64'(dPulse), 64'(0));
        sysReset = 1'b1;
        @(posedge ACLK);
        #1;
        checkOutput("rst_release_rready", 64'(mRready), 64'(1));

        // Basic route with one-cycle latency
        applyStimulus(3'd5, 1'b1, 32'hCAFE_0001, RRESP_OKAY, 1'b1, 1'b0);
        idleMaster();
        @(negedge ACLK);
        checkOutput("route_rvalid", 64'(sRvalid), 64'(8'h20));
        checkOutput("route_rid", 64'(sRid), 64'(1));
        @(negedge ACLK);
        checkOutput("route_popped", 64'(sRvalid), 64'(0));
        checkOutput("empty_rdata", 64'(sRdata), 64'(0));
        @(posedge ACLK);
        #1;

        // Backpressure on port 2
        sRready = 8'hFB;
        base = acceptedCount;
        applyStimulus(3'd2, 1'b0, 32'hB000_0001, RRESP_OKAY, 1'b0, 1'b0);
        applyStimulus(3'd2, 1'b1, 32'hB000_0002, RRESP_EXOKAY, 1'b0, 1'b0);
        mRvalid = 1'b1; mRid = {3'd2, 1'b0}; mRdata = 32'hB000_0003; mRresp = RRESP_SLVERR; mRlast = 1'b1;
        @(negedge ACLK);
        checkOutput("bp_rready_low", 64'(mRready), 64'(0));
        checkOutput("bp_head_valid", 64'(sRvalid), 64'(8'h04));
        repeat (2) @(negedge ACLK);
        checkOutput("bp_rready_held", 64'(mRready), 64'(0));
        checkOutput("bp_accepted", 64'(acceptedCount - base), 64'(2));
        @(posedge ACLK);
        #1;
        sRready = 8'hFF;
        applyStimulus(3'd2, 1'b0, 32'hB000_0003, RRESP_SLVERR, 1'b1, 1'b0);
        idleMaster();
        waitDrain("bp_drain");

        // Disconnected port 4, then normal delivery to port 1
        conn = 8'hEF;
        base = pulseCount;
        applyStimulus(3'd4, 1'b1, 32'hDEAD_0004, RRESP_OKAY, 1'b1, 1'b1);
        applyStimulus(3'd1, 1'b0, 32'h0000_1111, RRESP_OKAY, 1'b1, 1'b0);
        idleMaster();
        waitDrain("disc_drain");
        checkOutput("disc_pulse_count", 64'(pulseCount - base), 64'(1));
        checkOutput("disc_sticky", 64'(dSticky), 64'(1));
        conn = 8'hFF;

        // Interleaved ports 0 and 3 under random ready
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    applyStimulus((k % 2 == 0) ? 3'd0 : 3'd3, k[0] ^ k[1], 32'h0100_0000 + 32'(k),
                                  2'(k % 4), k[1], 1'b0);
                end
                idleMaster();
                stimDone = 1'b1;
            end
            begin
                while (!stimDone) begin
                    @(posedge ACLK);
                    #1;
                    sRready = 8'($urandom);
                end
            end
        join
        sRready = 8'hFF;
        waitDrain("ilv_drain");

        // Out-of-range port on the 6-port instance, then an in-range port
        @(posedge ACLK);
        #1;
        m6Rvalid = 1'b1; m6Rid = {3'd7, 1'b0}; m6Rdata = 32'h0000_0777; m6Rresp = RRESP_OKAY; m6Rlast = 1'b1;
        @(negedge ACLK);
        checkOutput("oor_rready", 64'(m6Rready), 64'(1));
        @(posedge ACLK);
        #1;
        m6Rvalid = 1'b0;
        @(negedge ACLK);
        checkOutput("oor_pulse", 64'(d6Pulse), 64'(1));
        checkOutput("oor_rvalid", 64'(s6Rvalid), 64'(0));
        @(negedge ACLK);
        checkOutput("oor_pulse_once", 64'(d6Pulse), 64'(0));
        checkOutput("oor_sticky", 64'(d6Sticky), 64'(1));
        @(posedge ACLK);
        #1;
        m6Rvalid = 1'b1; m6Rid = {3'd5, 1'b1}; m6Rdata = 32'h0000_0555; m6Rresp = RRESP_EXOKAY; m6Rlast = 1'b0;
        @(posedge ACLK);
        #1;
        m6Rvalid = 1'b0;
        @(negedge ACLK);
        checkOutput("n6_rvalid", 64'(s6Rvalid), 64'(6'h20));
        checkOutput("n6_rid", 64'(s6Rid), 64'(1));
        checkOutput("n6_rdata", 64'(s6Rdata), 64'(32'h0000_0555));
        checkOutput("n6_pulse", 64'(d6Pulse), 64'(0));
        @(posedge ACLK);
        #1;

        // Reset asserted while the buffer is full
        sRready = 8'h00;
        applyStimulus(3'd6, 1'b0, 32'h6000_0001, RRESP_OKAY, 1'b0, 1'b0);
        applyStimulus(3'd6, 1'b1, 32'h6000_0002, RRESP_OKAY, 1'b1, 1'b0);
        idleMaster();
        #1;
        checkOutput("two_rready", 64'(mRready), 64'(0));
        #1 sysReset = 1'b0;
        #1;
        sbQ.delete();
        checkOutput("mid_rst_rready", 64'(mRready), 64'(0));
        checkOutput("mid_rst_rvalid", 64'(sRvalid), 64'(0));
        checkOutput("mid_rst_rdata", 64'(sRdata), 64'(0));
        checkOutput("mid_rst_sticky", 64'(dSticky), 64'(0));
        checkOutput("mid_rst_sticky6", 64'(d6Sticky), 64'(0));
        @(negedge ACLK);
        sysReset = 1'b1;
        @(posedge ACLK);
        #1;
        checkOutput("post_rst_rready", 64'(mRready), 64'(1));
        checkOutput("post_rst_rvalid", 64'(sRvalid), 64'(0));
        sRready = 8'hFF;
        applyStimulus(3'd7, 1'b1, 32'h7777_0007, RRESP_DECERR, 1'b1, 1'b0);
        idleMaster();
        waitDrain("post_rst_drain");

        repeat (2) @(posedge ACLK);
        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule

// File: doc/caxi4interconnect_resp_router.md
CAXI4INTERCONNECT_RESP_ROUTER -- requirements
Module: caxi4interconnect_resp_router

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 8: number of requesting slave ports that responses return to.
REQ-002 SHALL have parameter NUM_SLAVES_WIDTH, default 3: bits encoding the slave-port number, carried in the upper ID bits.
REQ-003 SHALL have parameter ID_WIDTH, default 1: width of the original transaction ID below the port bits.
REQ-004 SHALL have parameter DATA_WIDTH, default 32: read-data width.
REQ-005 SHALL have port ACLK, input, 1: the only clock; all logic on its rising edge.
REQ-006 SHALL have port sysReset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port MASTER_RVALID / MASTER_RREADY, input / output, 1 each: response handshake from the downstream master port.
REQ-008 SHALL have port MASTER_RID, input, NUM_SLAVES_WIDTH+ID_WIDTH: [top NUM_SLAVES_WIDTH bits] = return port, [ID_WIDTH-1:0] = original ID.
REQ-009 SHALL have ports MASTER_RDATA (input, DATA_WIDTH), MASTER_RRESP (input, 2) and MASTER_RLAST (input, 1).
REQ-010 SHALL have port READ_CONNECTIVITY, input, NUM_SLAVES: per-port enable for the read path.
REQ-011 SHALL have port SLAVE_RVALID, output, NUM_SLAVES: one-hot per-port valid.
REQ-012 SHALL have port SLAVE_RREADY, input, NUM_SLAVES: per-port ready.
REQ-013 SHALL have shared output buses to all ports: SLAVE_RID (ID_WIDTH), SLAVE_RDATA (DATA_WIDTH), SLAVE_RRESP (2), SLAVE_RLAST (1).
REQ-014 SHALL have port DECERR_PULSE, output, 1: one-cycle pulse when a response is dropped.
REQ-015 SHALL have port DECERR_STICKY, output, 1: set on any drop; cleared only by reset.

Function
REQ-016 SHALL buffer accepted beats in a 2-entry FIFO skid buffer; occupancy states are EMPTY, ONE and TWO.
REQ-017 SHALL drive MASTER_RREADY from a register: 1 in EMPTY and ONE, 0 in TWO; no combinational path from SLAVE_RREADY to MASTER_RREADY.
REQ-018 SHALL accept a beat (push) when MASTER_RVALID && MASTER_RREADY; a beat pushed in cycle N SHALL be presentable at the outputs in cycle N+1 (1-cycle latency).
REQ-019 SHALL decode the head entry's port field p; the head is routable iff p < NUM_SLAVES && READ_CONNECTIVITY[p].
REQ-020 SHALL, for a routable head, assert only SLAVE_RVALID[p] and drive the shared buses from the head entry, with SLAVE_RID = head ID bits [ID_WIDTH-1:0].
REQ-021 SHALL pop a routable head when SLAVE_RVALID[p] && SLAVE_RREADY[p]; SLAVE_RREADY of other ports SHALL be ignored.
REQ-022 SHALL keep the head's valid and bus values stable until it is popped (AXI stability rule).
REQ-023 SHALL, for a non-routable head, keep SLAVE_RVALID all zero, pop the head that cycle, pulse DECERR_PULSE, and set DECERR_STICKY.
REQ-024 SHALL implement occupancy transitions as follows: push only -> +1; pop only -> -1; push and pop together -> unchanged. In TWO, push cannot occur.
REQ-025 SHALL treat each beat independently, with no burst locking: beats of different IDs may interleave as the master returns them, and RLAST passes through unmodified.
REQ-026 SHALL drive all-zero SLAVE_RVALID and zero shared buses when EMPTY.

Reset
REQ-027 SHALL, while sysReset = 0, force asynchronously: occupancy EMPTY, MASTER_RREADY = 0, SLAVE_RVALID = 0, buses = 0, DECERR_PULSE = 0, DECERR_STICKY = 0.
REQ-028 SHALL raise MASTER_RREADY on the first ACLK edge after reset release.
REQ-029 SHALL discard buffered beats on reset asserted mid-operation; no partial beat SHALL be presented afterwards.

Structure
REQ-030 SHALL place the RRESP encodings (OKAY = 0, EXOKAY = 1, SLVERR = 2, DECERR = 3) and the port-field extraction width rule in the shared interconnect package.
REQ-031 SHALL implement the 2-entry buffer as one sub-module, caxi4interconnect_resp_skid_buf, parameterised by payload width; the decode/route logic SHALL stay in this module.

Verification
REQ-032 SHALL verify the basic route: NUM_SLAVES = 8, one beat RID = {3'd5, 1'b1}, RDATA = 0xCAFE0001, RLAST = 1, port 5 ready -> SLAVE_RVALID = 0x20 in cycle N+1, SLAVE_RID = 1, popped that cycle.
REQ-033 SHALL verify backpressure: port 2 RREADY = 0 with 3 beats offered back-to-back -> 2 beats accepted, MASTER_RREADY = 0 from cycle N+2; on release, 3 beats delivered in order, no loss.
REQ-034 SHALL verify a disconnected port: READ_CONNECTIVITY[4] = 0, beat to port 4 -> no SLAVE_RVALID, one DECERR_PULSE, DECERR_STICKY = 1, next beat to port 1 delivered normally.
REQ-035 SHALL verify an out-of-range port: NUM_SLAVES = 6, NUM_SLAVES_WIDTH = 3, RID port = 7 -> dropped with DECERR_PULSE.
REQ-036 SHALL verify interleaving: alternating beats to ports 0 and 3 under random ready at 50% -> per-port data order preserved, RLAST passed through unchanged.
REQ-037 SHALL verify reset mid-operation: sysReset asserted while in TWO -> all outputs 0 immediately; after release MASTER_RREADY = 1, SLAVE_RVALID = 0.
